// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the shift-and-add multiplier controller:
// FSM state encodings and the opcodes of the companion ALU.
package mult_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_SLLI = 5'b10101;
  localparam logic [4:0] OP_NOP  = 5'b00001;

  localparam logic [3:0] CNT_LAST = 4'd15;

endpackage

// File: rtl/mult_ctrl.sv
// Shift-and-add 16x16 multiplier controller that sequences an external ALU:
// one ADD/SHIFT pair per multiplier bit, low 16 bits of the product kept.
module mult_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int EARLY_EXIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        err,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic [4:0]  alu_Op,
  output logic        alu_Cin,
  output logic        alu_invA,
  output logic        alu_invB,
  output logic [1:0]  alu_lower_two,
  input  logic [15:0] alu_Out,
  input  logic        alu_err
);

  state_t      state_reg, state_next;
  logic [15:0] mcand_reg, mcand_next;
  logic [15:0] mplier_reg, mplier_next;
  logic [15:0] acc_reg, acc_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [15:0] result_reg, result_next;
  logic        err_reg, err_next;
  logic [15:0] mplier_shr;

  assign mplier_shr = mplier_reg >> 1;

  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    result_next = result_reg;
    err_next    = 1'b0;
    alu_A       = 16'h0000;
    alu_B       = 16'h0000;
    alu_Op      = OP_NOP;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          mcand_next  = a;
          mplier_next = b;
          acc_next    = 16'h0000;
          cnt_next    = 4'd0;
          state_next  = ST_ADD;
        end
      end
      ST_ADD: begin
        if (mplier_reg[0]) begin
          alu_A    = acc_reg;
          alu_B    = mcand_reg;
          alu_Op   = OP_ADDI;
          acc_next = alu_Out;
        end
        state_next = ST_SHIFT;
        // An ALU fault abandons the operation without touching the operands.
        if (alu_err) begin
          acc_next   = acc_reg;
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        alu_A       = mcand_reg;
        alu_B       = 16'h0001;
        alu_Op      = OP_SLLI;
        mcand_next  = alu_Out;
        mplier_next = mplier_shr;
        cnt_next    = (cnt_reg == CNT_LAST) ? cnt_reg : cnt_reg + 4'd1;
        if ((cnt_reg == CNT_LAST) || ((EARLY_EXIT != 0) && (mplier_shr == 16'h0000)))
          state_next = ST_DONE;
        else
          state_next = ST_ADD;
        if (alu_err) begin
          mcand_next  = mcand_reg;
          mplier_next = mplier_reg;
          cnt_next    = cnt_reg;
          err_next    = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      ST_DONE: begin
        result_next = acc_reg;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      mcand_reg  <= 16'h0000;
      mplier_reg <= 16'h0000;
      acc_reg    <= 16'h0000;
      cnt_reg    <= 4'd0;
      result_reg <= 16'h0000;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
      err_reg    <= err_next;
    end
  end

  assign busy          = (state_reg != ST_IDLE);
  assign done          = (state_reg == ST_DONE);
  assign result        = result_reg;
  assign err           = err_reg;
  assign alu_Cin       = 1'b0;
  assign alu_invA      = 1'b0;
  assign alu_invB      = 1'b0;
  assign alu_lower_two = 2'b00;

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: two instances (early exit on/off) each driving a
// behavioural ALU; table of directed multiplies plus hand-written corner cases.
module tb_mult_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start1, start0, err_inj;
  logic [15:0] a, b;

  logic        busy1, done1, err1, cin1, inva1, invb1, alu_err1;
  logic [15:0] result1, alu_A1, alu_B1, alu_Out1;
  logic [4:0]  alu_Op1;
  logic [1:0]  low1;

  logic        busy0, done0, err0, cin0, inva0, invb0, alu_err0;
  logic [15:0] result0, alu_A0, alu_B0, alu_Out0;
  logic [4:0]  alu_Op0;
  logic [1:0]  low0;

  int errors = 0;
  int checks = 0;

  function automatic logic [15:0] alu_model(input logic [4:0] op, input logic [15:0] x,
                                            input logic [15:0] y);
    case (op)
      5'b01000: return x + y;
      5'b10101: return x << y[3:0];
      default:  return 16'h0000;
    endcase
  endfunction

  assign alu_Out1 = alu_model(alu_Op1, alu_A1, alu_B1);
  assign alu_err1 = err_inj && (alu_Op1 == 5'b10101);
  assign alu_Out0 = alu_model(alu_Op0, alu_A0, alu_B0);
  assign alu_err0 = 1'b0;

  mult_ctrl #(.EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a), .b(b),
    .busy(busy1), .done(done1), .result(result1), .err(err1),
    .alu_A(alu_A1), .alu_B(alu_B1), .alu_Op(alu_Op1),
    .alu_Cin(cin1), .alu_invA(inva1), .alu_invB(invb1), .alu_lower_two(low1),
    .alu_Out(alu_Out1), .alu_err(alu_err1)
  );

  mult_ctrl #(.EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a), .b(b),
    .busy(busy0), .done(done0), .result(result0), .err(err0),
    .alu_A(alu_A0), .alu_B(alu_B0), .alu_Op(alu_Op0),
    .alu_Cin(cin0), .alu_invA(inva0), .alu_invB(invb0), .alu_lower_two(low0),
    .alu_Out(alu_Out0), .alu_err(alu_err0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge with the chosen instance idle; lat is the edge
  // index (start edge = 0) after which done was first seen, -1 on timeout.
  task automatic run_op(input bit ee, input logic [15:0] va, input logic [15:0] vb,
                        output int lat, output logic [15:0] res, output logic pulse_ok);
    a = va;
    b = vb;
    if (ee) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start1 = 1'b0;
    start0 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ee ? done1 : done0) begin
        lat = k;
        break;
      end
    end
    tick();
    pulse_ok = !(ee ? done1 : done0);
    res      = ee ? result1 : result0;
  endtask

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    bit          ee;
    int          lat;
    logic [15:0] res;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int          lat;
    logic [15:0] res;
    logic        pulse_ok;
    bit          seen;

    vecs[0] = '{16'h0003, 16'h0005, 1'b1, 6,  16'h000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 32, 16'h0001};
    vecs[2] = '{16'h1234, 16'h0000, 1'b1, 2,  16'h0000};
    vecs[3] = '{16'h1234, 16'h0000, 1'b0, 32, 16'h0000};
    vecs[4] = '{16'h0007, 16'h0001, 1'b1, 2,  16'h0007};
    vecs[5] = '{16'h0003, 16'h8000, 1'b1, 32, 16'h8000};
    vecs[6] = '{16'h0003, 16'h0005, 1'b0, 32, 16'h000F};

    rst = 1'b1; start1 = 1'b1; start0 = 1'b1; err_inj = 1'b0;
    a = 16'h1111; b = 16'h2222;
    tick();
    tick();
    chk("rst_busy",   {31'd0, busy1}, 32'd0);
    chk("rst_done",   {31'd0, done1}, 32'd0);
    chk("rst_err",    {31'd0, err1},  32'd0);
    chk("rst_result", {16'd0, result1}, 32'd0);
    chk("rst_op",     {27'd0, alu_Op1}, 32'h01);
    chk("rst_busy0",  {31'd0, busy0}, 32'd0);
    rst = 1'b0; start1 = 1'b0; start0 = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].ee, vecs[i].va, vecs[i].vb, lat, res, pulse_ok);
      $display("vec %0d: a=%h b=%h ee=%0d lat=%0d result=%h", i, vecs[i].va, vecs[i].vb,
               vecs[i].ee, lat, res);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_result", i), {16'd0, res}, {16'd0, vecs[i].res});
      chk($sformatf("vec%0d_pulse", i), {31'd0, pulse_ok}, 32'd1);
    end

    // ALU drive per state, and start ignored while busy and in DONE.
    a = 16'h0003; b = 16'h0005; start1 = 1'b1;
    tick();                                   // E0
    start1 = 1'b0; a = 16'h0707; b = 16'h0909;
    chk("add_busy", {31'd0, busy1}, 32'd1);
    chk("add_op",   {27'd0, alu_Op1}, 32'h08);
    chk("add_A",    {16'd0, alu_A1}, 32'h0000);
    chk("add_B",    {16'd0, alu_B1}, 32'h0003);
    tick();                                   // E1
    chk("shift_op", {27'd0, alu_Op1}, 32'h15);
    chk("shift_A",  {16'd0, alu_A1}, 32'h0003);
    chk("shift_B",  {16'd0, alu_B1}, 32'h0001);
    chk("ctl_zero", {27'd0, cin1, inva1, invb1, low1}, 32'd0);
    tick();                                   // E2
    chk("nop_op",   {27'd0, alu_Op1}, 32'h01);
    chk("nop_AB",   {alu_A1, alu_B1}, 32'd0);
    tick();                                   // E3
    tick();                                   // E4
    start1 = 1'b1;
    tick();                                   // E5
    tick();                                   // E6
    chk("ign_done", {31'd0, done1}, 32'd1);
    tick();                                   // E7
    start1 = 1'b0;
    chk("ign_done_off", {31'd0, done1}, 32'd0);
    chk("ign_busy",     {31'd0, busy1}, 32'd0);
    chk("ign_result",   {16'd0, result1}, 32'h000F);
    tick();                                   // E8
    chk("ign_idle", {31'd0, busy1}, 32'd0);
    $display("seq ignore-start: result=%h", result1);

    // Reset in the middle of a 16-iteration operation.
    run_op(1'b1, 16'h0003, 16'h8000, lat, res, pulse_ok);
    a = 16'hFFFF; b = 16'hFFFF; start1 = 1'b1;
    tick();                                   // E0
    start1 = 1'b0;
    for (int k = 1; k <= 9; k++) tick();      // E9
    rst = 1'b1;
    tick();                                   // E10
    rst = 1'b0;
    chk("mrst_busy",   {31'd0, busy1}, 32'd0);
    chk("mrst_result", {16'd0, result1}, 32'd0);
    chk("mrst_done",   {31'd0, done1}, 32'd0);
    chk("mrst_op",     {27'd0, alu_Op1}, 32'h01);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done1) seen = 1'b1;
    end
    chk("mrst_nodone", {31'd0, seen}, 32'd0);
    $display("seq mid-op reset: busy=%0d result=%h", busy1, result1);

    // ALU error in the first SHIFT.
    run_op(1'b1, 16'h0003, 16'h0005, lat, res, pulse_ok);
    err_inj = 1'b1;
    a = 16'h0009; b = 16'h0003; start1 = 1'b1;
    tick();                                   // E0
    start1 = 1'b0;
    tick();                                   // E1
    chk("aerr_inshift", {31'd0, busy1}, 32'd1);
    tick();                                   // E2
    chk("aerr_err",  {31'd0, err1},  32'd1);
    chk("aerr_busy", {31'd0, busy1}, 32'd0);
    chk("aerr_done", {31'd0, done1}, 32'd0);
    err_inj = 1'b0;
    tick();                                   // E3
    chk("aerr_err_off", {31'd0, err1}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done1) seen = 1'b1;
    end
    chk("aerr_nodone", {31'd0, seen}, 32'd0);
    chk("aerr_result", {16'd0, result1}, 32'h000F);
    $display("seq alu-error: result=%h", result1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 SHALL have parameter EARLY_EXIT, default 1; when 1, iterating stops once the remaining multiplier is zero.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1: request a multiply; sampled only in IDLE.
REQ-005 SHALL have port a, input, 16: multiplicand, captured on an accepted start.
REQ-006 SHALL have port b, input, 16: multiplier, captured on an accepted start.
REQ-007 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-008 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-009 SHALL have port result, output, 16: low 16 bits of a*b; held until the next accepted start.
REQ-010 SHALL have port err, output, 1: one-cycle abort pulse.
REQ-011 SHALL have ports alu_A and alu_B, output, 16: ALU operands.
REQ-012 SHALL have port alu_Op, output, 5: ALU opcode.
REQ-013 SHALL have ports alu_Cin, alu_invA and alu_invB, output, 1 each: ALU carry-in and operand-invert controls.
REQ-014 SHALL have port alu_lower_two, output, 2: ALU sub-op select.
REQ-015 SHALL have port alu_Out, input, 16: ALU result.
REQ-016 SHALL have port alu_err, input, 1: ALU illegal-op flag.

Function
REQ-017 SHALL implement FSM states IDLE, ADD, SHIFT and DONE.
REQ-018 In IDLE, start=1 SHALL load mcand<=a, mplier<=b, acc<=0 and cnt<=0, then go to ADD.
REQ-019 Start outside IDLE, including in DONE, SHALL be ignored with no effect on state or operands.
REQ-020 In ADD with mplier[0]=1, the block SHALL drive alu_A=acc, alu_B=mcand, alu_Op=5'b01000 (ADDI), latch acc<=alu_Out and go to SHIFT.
REQ-021 In ADD with mplier[0]=0, the block SHALL drive alu_Op=5'b00001 (NOP) with alu_A=alu_B=0, hold acc and go to SHIFT.
REQ-022 In SHIFT, the block SHALL drive alu_A=mcand, alu_B=16'h0001, alu_Op=5'b10101 (SLLI), latch mcand<=alu_Out, set mplier<=mplier>>1 and cnt<=cnt+1.
REQ-023 SHIFT SHALL go to DONE if cnt==15, or if EARLY_EXIT=1 and (mplier>>1)==0; otherwise it SHALL go to ADD.
REQ-024 DONE SHALL assert done=1 for exactly one cycle, load result<=acc and return to IDLE.
REQ-025 Latency: for n iterations, with start sampled at edge E0, done SHALL be high in the cycle after edge E(2n); n ranges 1..16.
REQ-026 In IDLE and DONE the block SHALL drive alu_Op=5'b00001 and alu_A=alu_B=0.
REQ-027 alu_Cin, alu_invA, alu_invB and alu_lower_two SHALL be constant 0 in every state.
REQ-028 Arithmetic SHALL be modulo 2^16, with no overflow flag; the low 16 bits are identical for signed and unsigned operands.
REQ-029 If alu_err=1 in ADD or SHIFT, the FSM SHALL go to IDLE with err=1 for one cycle, done=0 and result unchanged.
REQ-030 The 4-bit cnt SHALL never wrap; its terminal value is 15.

Reset
REQ-031 While rst=1, state SHALL be IDLE and busy, done and err SHALL be 0.
REQ-032 While rst=1, result, acc, mcand, mplier and cnt SHALL be 0, and alu_Op SHALL be 5'b00001.
REQ-033 Reset SHALL take priority over start and over an in-flight operation; no done is produced for an aborted operation.

Structure
REQ-034 The ALU opcode constants (ADDI 01000, SLLI 10101, NOP 00001) and the state encodings SHALL live in a shared include/package and SHALL NOT be duplicated in this module.
REQ-035 The block SHALL be a single module with FSM, counter and registers inline; the ALU is instantiated beside it, not inside it.

Verification
REQ-036 Bench SHALL cover: a=3, b=5, EARLY_EXIT=1 -> n=3, done after E6, result=15.
REQ-037 Bench SHALL cover: a=16'hFFFF, b=16'hFFFF -> n=16, done after E32, result=16'h0001.
REQ-038 Bench SHALL cover: a=16'h1234, b=0 -> done after E2, result=0; with EARLY_EXIT=0 -> done after E32, result=0.
REQ-039 Bench SHALL cover: start pulsed again at E5 while busy with a=3, b=5 -> ignored, result=15 at E6.
REQ-040 Bench SHALL cover: rst=1 at E10 of a 16-iteration operation -> IDLE next cycle, busy=0, result=0, no done pulse.
REQ-041 Bench SHALL cover: alu_err forced high in the first SHIFT -> err pulse, busy=0 next cycle, done never asserted, result unchanged.
